uart_tx_periph: RTL

Memory-mapped UART transmitter that responds to the core's load/store data bus (`cs`, `wr`, `mask`, `addr`, `data_wr`, `data_rd`). It is the peripheral end of the LSU interface and sits beside the data memory behind an external address-decode chip select. Stores to its registers push bytes into a small TX FIFO. A baud-rate state machine then serialises each byte on `tx` as 8N1, with an optional parity bit.

---
 rtl/uart_tx_periph_if.sv | 14 +
 rtl/uart_tx_periph.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_periph_if.sv
// Load/store data-bus port of the UART transmitter; the core LSU is master, the peripheral is slave.
// Latency: none added; read data is combinational at the slave.
// Backpressure: none; every access completes in the cycle it is presented.
interface uart_tx_periph_if;
    logic        cs;
    logic        wr;
    logic [3:0]  mask;
    logic [31:0] addr;
    logic [31:0] data_wr;
    logic [31:0] data_rd;

    modport master (output cs, wr, mask, addr, data_wr, input data_rd);
    modport slave  (input cs, wr, mask, addr, data_wr, output data_rd);
endinterface

// File: rtl/uart_tx_periph.sv
// Memory-mapped UART transmitter: TXDATA stores fill a TX FIFO, an FSM sends 8N1 (parity bit when UART_TX_PARITY_EN is defined).
// Latency: TXDATA store at edge N pops and drives the start bit after edge N+1; each bit lasts the divider latched at frame start.
// Backpressure: none on the bus; a store to a full FIFO is dropped and raises the sticky STATUS overflow flag.
module uart_tx_periph #(
    parameter int FIFO_DEPTH  = 4,
    parameter int DEFAULT_DIV = 16
) (
    input  logic            clk,
    input  logic            rst,
    uart_tx_periph_if.slave bus,
    output logic            tx,
    output logic            busy
);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_e;

    state_e          state_q, state_d;
    logic [7:0]      mem_q [FIFO_DEPTH];
    logic [7:0]      mem_d [FIFO_DEPTH];
    logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]   count_q, count_d;
    logic            ovf_q, ovf_d;
    logic [15:0]     baud_q, baud_d;
    logic            en_q, en_d;
    logic [15:0]     div_q, div_d;
    logic [15:0]     timer_q, timer_d;
    logic [2:0]      idx_q, idx_d;
    logic [7:0]      shift_q, shift_d;
    logic            tx_q, tx_d;
`ifdef UART_TX_PARITY_EN
    logic            odd_q, odd_d;
    logic            par_q, par_d;
`endif

    logic        wr_acc, push, push_ok, pop, full, empty, bit_end, frame_go;
    logic [15:0] div_eff;
    logic [31:0] rd_dat;
    logic        unused_bits;

    assign wr_acc  = bus.cs & bus.wr;
    assign push    = wr_acc && (bus.addr[3:2] == 2'd0) && bus.mask[0];
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign empty   = (count_q == '0);
    assign push_ok = push & ~full;
    assign div_eff = (baud_q == 16'd0) ? 16'd1 : baud_q;
    assign bit_end = (timer_q == div_q - 16'd1);
    // A new frame starts from IDLE or straight out of the last stop-bit cycle.
    assign frame_go = en_q && !empty && ((state_q == IDLE) || ((state_q == STOP) && bit_end));
    assign busy    = (state_q != IDLE) || !empty;
    assign tx      = tx_q;
    assign unused_bits = ^{bus.addr[31:4], bus.addr[1:0], bus.data_wr[31:16], bus.mask[3:2]};

    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (push_ok) begin
            mem_d[wr_ptr_q] = bus.data_wr[7:0];
            wr_ptr_d        = wr_ptr_q + PW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
        count_d = count_q + CW'(push_ok) - CW'(pop);

        ovf_d = ovf_q;
        if (push && full) begin
            ovf_d = 1'b1;
        end else if (wr_acc && (bus.addr[3:2] == 2'd1) && bus.mask[0] && bus.data_wr[3]) begin
            ovf_d = 1'b0;
        end

        baud_d = baud_q;
        if (wr_acc && (bus.addr[3:2] == 2'd2)) begin
            if (bus.mask[0]) baud_d[7:0]  = bus.data_wr[7:0];
            if (bus.mask[1]) baud_d[15:8] = bus.data_wr[15:8];
        end

        en_d = en_q;
`ifdef UART_TX_PARITY_EN
        odd_d = odd_q;
`endif
        if (wr_acc && (bus.addr[3:2] == 2'd3) && bus.mask[0]) begin
            en_d = bus.data_wr[0];
`ifdef UART_TX_PARITY_EN
            odd_d = bus.data_wr[1];
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        timer_d = timer_q;
        idx_d   = idx_q;
        shift_d = shift_q;
        div_d   = div_q;
        pop     = 1'b0;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        if (state_q != IDLE) begin
            timer_d = bit_end ? 16'd0 : timer_q + 16'd1;
        end
        case (state_q)
            IDLE: ;
            START: if (bit_end) begin
                state_d = DATA;
                idx_d   = 3'd0;
            end
            DATA: if (bit_end) begin
                shift_d = {1'b0, shift_q[7:1]};
                idx_d   = idx_q + 3'd1;
                if (idx_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                    state_d = PARITY;
`else
                    state_d = STOP;
`endif
                end
            end
`ifdef UART_TX_PARITY_EN
            PARITY: if (bit_end) state_d = STOP;
`endif
            STOP: if (bit_end) state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // The divider is sampled once per frame so BAUDDIV writes never stretch a frame in flight.
        if (frame_go) begin
            pop     = 1'b1;
            state_d = START;
            timer_d = 16'd0;
            div_d   = div_eff;
            shift_d = mem_q[rd_ptr_q];
`ifdef UART_TX_PARITY_EN
            par_d   = (^mem_q[rd_ptr_q]) ^ odd_q;
`endif
        end

        case (state_d)
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            PARITY:  tx_d = par_d;
`endif
            default: tx_d = 1'b1;
        endcase
    end

    always_comb begin
        rd_dat = '0;
        if (bus.cs && !bus.wr) begin
            case (bus.addr[3:2])
                2'd1: begin
                    rd_dat[0]    = busy;
                    rd_dat[1]    = full;
                    rd_dat[2]    = empty;
                    rd_dat[3]    = ovf_q;
                    rd_dat[11:8] = 4'(count_q);
                end
                2'd2: rd_dat[15:0] = baud_q;
                2'd3: begin
                    rd_dat[0] = en_q;
`ifdef UART_TX_PARITY_EN
                    rd_dat[1] = odd_q;
`endif
                end
                default: rd_dat = '0;
            endcase
        end
    end
    assign bus.data_rd = rd_dat;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            ovf_q    <= 1'b0;
            baud_q   <= 16'(DEFAULT_DIV);
            en_q     <= 1'b1;
            div_q    <= 16'(DEFAULT_DIV);
            timer_q  <= '0;
            idx_q    <= '0;
            shift_q  <= '0;
            tx_q     <= 1'b1;
`ifdef UART_TX_PARITY_EN
            odd_q    <= 1'b0;
            par_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            ovf_q    <= ovf_d;
            baud_q   <= baud_d;
            en_q     <= en_d;
            div_q    <= div_d;
            timer_q  <= timer_d;
            idx_q    <= idx_d;
            shift_q  <= shift_d;
            tx_q     <= tx_d;
`ifdef UART_TX_PARITY_EN
            odd_q    <= odd_d;
            par_q    <= par_d;
`endif
        end
    end
endmodule
